// File: rtl/dff_pkg.sv
// Shared definitions for the dff_pipe pipeline register.
package dff_pkg;

   localparam int unsigned DFF_PIPE_DEPTH_DEFAULT = 2;
   localparam int unsigned DFF_PIPE_WIDTH_MAX     = 64;

   // State of one pipeline stage, sized for the widest supported word.
   typedef struct packed {
      logic                          valid;
      logic [DFF_PIPE_WIDTH_MAX-1:0] data;
   } dff_stage_t;

   // Ceiling log2, never below 1 so that a count of zero still has a port bit.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned bits;
      bits = 0;
      while ((32'd1 << bits) < value) bits++;
      return (bits == 0) ? 1 : bits;
   endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: valid flag plus data word, loads from upstream when advanced.
module dff_pipe_stage #(
   parameter int unsigned      WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             adv,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   // Data only loads with a valid word so bubbles never disturb the held value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= RESET_VALUE;
      end else if (clr) begin
         valid <= 1'b0;
      end else if (adv) begin
         valid <= up_valid;
         if (up_valid) begin
            data <= up_data;
         end
      end
   end

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage valid/ready pipeline register with bubble collapse.
// Optional synchronous flush port when DFF_PIPE_FLUSH_EN is defined.
module dff_pipe
   import dff_pkg::*;
#(
   parameter int unsigned      WIDTH       = 1,
   parameter int unsigned      DEPTH       = DFF_PIPE_DEPTH_DEFAULT,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic                      clk,
   input  logic                      rst_n,
`ifdef DFF_PIPE_FLUSH_EN
   input  logic                      flush,
`endif
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [clog2(DEPTH+1)-1:0] occ
);

   localparam int unsigned OCC_W = clog2(DEPTH + 1);

   if (DEPTH == 0) begin : g_wire
      // No storage: straight wires in both directions.
      assign out_valid = in_valid;
      assign out_data  = in_data;
      assign in_ready  = out_ready;
      assign occ       = '0;
   end else begin : g_pipe
      logic             clr;
      logic [DEPTH-1:0] adv;
      logic [DEPTH:0]   vch;
      logic [WIDTH-1:0] dch [DEPTH+1];

`ifdef DFF_PIPE_FLUSH_EN
      assign clr = flush;
`else
      assign clr = 1'b0;
`endif

      assign vch[0] = in_valid;
      assign dch[0] = in_data;

      for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
         // Unrolled ready chain: advance if any later stage is empty or the sink takes a word.
         assign adv[i] = out_ready | ~(&vch[DEPTH:i+1]);

         dff_pipe_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
         ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr),
            .adv      (adv[i]),
            .up_valid (vch[i]),
            .up_data  (dch[i]),
            .valid    (vch[i+1]),
            .data     (dch[i+1])
         );
      end

      // Input is refused during reset and during a flush cycle.
      assign in_ready  = adv[0] & rst_n & ~clr;
      assign out_valid = vch[DEPTH];
      assign out_data  = dch[DEPTH];
      assign occ       = OCC_W'($countones(vch[DEPTH:1]));
   end

endmodule

// File: tb/tb_dff_pipe.sv
// Scoreboard bench for dff_pipe (WIDTH=8, DEPTH=3, RESET_VALUE=8'hA5).
module tb_dff_pipe;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [1:0] occ;
`ifdef DFF_PIPE_FLUSH_EN
   logic       flush;
`endif

   int         checks;
   int         passes;
   int         cyc;
   int         stalls;
   int         last_acc_cyc;
   int         first_acc;
   logic [7:0] exp_q [$];
   int         pop_cyc [$];

   dff_pipe #(
      .WIDTH       (8),
      .DEPTH       (3),
      .RESET_VALUE (8'hA5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef DFF_PIPE_FLUSH_EN
      .flush     (flush),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occ       (occ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      checks++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Monitor: every output handshake pops the oldest expected word.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         pop_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL out_unexpected: got 0x%0h, expected no output", out_data);
         end else begin
            check("out_data", int'(out_data), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one word, hold until accepted; in_valid stays high on return.
   task automatic send(input logic [7:0] w);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = w;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(w);
            last_acc_cyc = cyc;
            tick(1);
            break;
         end
         tick(1);
         n++;
         stalls++;
         if (n > 40) begin
            fail_now("send_timeout");
            break;
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 || occ != 2'd0) begin
         tick(1);
         n++;
         if (n >= 50) begin
            fail_now("drain_timeout");
            break;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; passes = 0; cyc = 0; stalls = 0;
      rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
`ifdef DFF_PIPE_FLUSH_EN
      flush = 1'b0;
`endif
      // Reset state
      tick(2);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 'hA5);
      check("rst_occ", int'(occ), 0);
      check("rst_in_ready", int'(in_ready), 0);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready", int'(in_ready), 1);

      // Streaming 0x01..0x0A at full rate
      pop_cyc.delete();
      stalls = 0;
      for (int k = 1; k <= 10; k++) begin
         send(8'(k));
         if (k == 1) first_acc = last_acc_cyc;
      end
      drain();
      check("stream_count", pop_cyc.size(), 10);
      if (pop_cyc.size() == 10) begin
         check("stream_latency", pop_cyc[0] - first_acc, 3);
         check("stream_rate", pop_cyc[9] - pop_cyc[0], 9);
      end
      check("stream_stalls", stalls, 0);
      check("empty_out_valid", int'(out_valid), 0);
      check("empty_out_data", int'(out_data), 'h0A);

      // Backpressure: three accepts then in_ready drops
      out_ready = 1'b0;
      send(8'h11); send(8'h12); send(8'h13);
      in_data = 8'h14;
      @(negedge clk);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_occ", int'(occ), 3);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_data", int'(out_data), 'h11);
      @(negedge clk);
      check("bp_hold_data", int'(out_data), 'h11);
      check("bp_hold_ready", int'(in_ready), 0);
      tick(1);
      out_ready = 1'b1;
      send(8'h14); send(8'h15);
      drain();

      // Bubble collapse: two words four cycles apart, sink stalled
      out_ready = 1'b0;
      send(8'h21);
      in_valid = 1'b0;
      tick(3);
      send(8'h22);
      in_valid = 1'b0;
      tick(3);
      @(negedge clk);
      check("bub_occ", int'(occ), 2);
      check("bub_out_valid", int'(out_valid), 1);
      check("bub_out_data", int'(out_data), 'h21);
      check("bub_in_ready", int'(in_ready), 1);
      pop_cyc.delete();
      tick(1);
      drain();
      check("bub_count", pop_cyc.size(), 2);
      if (pop_cyc.size() == 2) check("bub_adjacent", pop_cyc[1] - pop_cyc[0], 1);

      // Full pass-through: one in, one out per cycle
      out_ready = 1'b0;
      send(8'h31); send(8'h32); send(8'h33);
      out_ready = 1'b1;
      stalls = 0;
      for (int k = 0; k < 6; k++) begin
         send(8'(8'h34 + k));
         check("full_occ", int'(occ), 3);
      end
      check("full_stalls", stalls, 0);
      drain();

      // Reset mid-stream
      out_ready = 1'b0;
      send(8'h41); send(8'h42);
      in_valid = 1'b0;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("mid_rst_out_valid", int'(out_valid), 0);
      check("mid_rst_out_data", int'(out_data), 'hA5);
      check("mid_rst_occ", int'(occ), 0);
      check("mid_rst_in_ready", int'(in_ready), 0);
      tick(1);
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", int'(in_ready), 1);
      check("post_rst_out_data", int'(out_data), 'hA5);

`ifdef DFF_PIPE_FLUSH_EN
      // Flush with a full chain and a word offered
      send(8'h51); send(8'h52); send(8'h53);
      in_data = 8'h54;
      flush = 1'b1;
      @(negedge clk);
      check("fl_in_ready", int'(in_ready), 0);
      check("fl_out_valid", int'(out_valid), 1);
      tick(1);
      flush = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      #1;
      check("fl_occ", int'(occ), 0);
      check("fl_out_valid_after", int'(out_valid), 0);
      check("fl_data_kept", int'(out_data), 'h51);
      out_ready = 1'b1;
      send(8'h61);
      drain();
`endif

      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
